// File: rtl/switch_event_gen.sv
// Per-switch press/release/long-press/auto-repeat pulse generator with a held level.
// Optional periodic o_Repeat in the LONG state is built only when SWITCH_EVENT_REPEAT_EN is defined.
module switch_event_gen #(
    parameter int NUM_SWITCHES      = 4,
    parameter int LONG_PRESS_CYCLES = 25000000,
    parameter int REPEAT_CYCLES     = 5000000
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [NUM_SWITCHES-1:0] i_Switches,
    output logic [NUM_SWITCHES-1:0] o_Press,
    output logic [NUM_SWITCHES-1:0] o_Release,
    output logic [NUM_SWITCHES-1:0] o_Long,
    output logic [NUM_SWITCHES-1:0] o_Repeat,
    output logic [NUM_SWITCHES-1:0] o_Held
);

    localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] LOAD_LONG = CW'(LONG_PRESS_CYCLES - 1);
`ifdef SWITCH_EVENT_REPEAT_EN
    localparam logic [CW-1:0] LOAD_REPEAT = CW'(REPEAT_CYCLES - 1);
`else
    localparam logic [CW-1:0] LOAD_REPEAT = '0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } state_t;

    for (genvar k = 0; k < NUM_SWITCHES; k++) begin : g_sw
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          prev;
        logic          rise;
        logic          fall;
        logic          press_nxt;
        logic          release_nxt;
        logic          long_nxt;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          held_q;
`ifdef SWITCH_EVENT_REPEAT_EN
        logic          repeat_nxt;
        logic          repeat_q;
`endif

        assign rise = i_Switches[k] & ~prev;
        assign fall = ~i_Switches[k] & prev;

        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            long_nxt    = 1'b0;
`ifdef SWITCH_EVENT_REPEAT_EN
            repeat_nxt  = 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A fall here is the release of a switch held through reset: ignored.
                    if (rise) begin
                        state_nxt = HELD;
                        cnt_nxt   = LOAD_LONG;
                        press_nxt = 1'b1;
                    end
                end
                HELD: begin
                    if (fall) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else if (cnt == '0) begin
                        state_nxt = LONG;
                        cnt_nxt   = LOAD_REPEAT;
                        long_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end
`ifdef SWITCH_EVENT_REPEAT_EN
                    else if (cnt == '0) begin
                        cnt_nxt    = LOAD_REPEAT;
                        repeat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
`endif
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                state     <= IDLE;
                cnt       <= '0;
                prev      <= i_Switches[k];
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                prev      <= i_Switches[k];
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
                held_q    <= (state_nxt != IDLE);
            end
        end

        assign o_Press[k]   = press_q;
        assign o_Release[k] = release_q;
        assign o_Long[k]    = long_q;
        assign o_Held[k]    = held_q;

`ifdef SWITCH_EVENT_REPEAT_EN
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                repeat_q <= 1'b0;
            end else begin
                repeat_q <= repeat_nxt;
            end
        end
        assign o_Repeat[k] = repeat_q;
`else
        assign o_Repeat[k] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_switch_event_gen.sv
// Bench for switch_event_gen: vector table, hand-written corner sequences, random stimulus vs an arithmetic model.
module tb_switch_event_gen;

    localparam int N = 4;
    localparam int L = 8;
    localparam int R = 3;
`ifdef SWITCH_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk;
    logic         i_Reset;
    logic [N-1:0] i_Switches;
    logic [N-1:0] o_Press, o_Release, o_Long, o_Repeat, o_Held;

    switch_event_gen #(
        .NUM_SWITCHES     (N),
        .LONG_PRESS_CYCLES(L),
        .REPEAT_CYCLES    (R)
    ) dut (
        .i_Clk     (clk),
        .i_Reset   (i_Reset),
        .i_Switches(i_Switches),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Long    (o_Long),
        .o_Repeat  (o_Repeat),
        .o_Held    (o_Held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: a press is remembered by the cycle it was reported; events follow from elapsed time.
    int           cyc = 0;
    bit           m_held [N];
    int           m_t0   [N];
    logic [N-1:0] m_prev;
    logic [N-1:0] e_press, e_rel, e_long, e_rep, e_held;

    task automatic model_update(input logic [N-1:0] sw, input logic rst);
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int k = 0; k < N; k++) begin
            if (rst) begin
                m_held[k] = 1'b0;
            end else if (!m_held[k]) begin
                if (sw[k] && !m_prev[k]) begin
                    e_press[k] = 1'b1;
                    m_held[k]  = 1'b1;
                    m_t0[k]    = cyc;
                end
            end else if (!sw[k]) begin
                e_rel[k]  = 1'b1;
                m_held[k] = 1'b0;
            end else begin
                int d;
                d = cyc - m_t0[k];
                if (d == L) e_long[k] = 1'b1;
                else if (REP_EN && d > L && ((d - L) % R) == 0) e_rep[k] = 1'b1;
            end
            e_held[k] = m_held[k];
        end
        m_prev = sw;
        cyc++;
    endtask

    task automatic check_vec(input string name, input logic [5*N-1:0] act, input logic [5*N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got press/rel/long/rep/held=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [5*N-1:0] dut_out();
        return {o_Press, o_Release, o_Long, o_Repeat, o_Held};
    endfunction

    // Apply inputs for one edge, advance the model, sample outputs 1 time unit after the edge.
    task automatic drive(input logic [N-1:0] sw, input logic rst);
        i_Switches = sw;
        i_Reset    = rst;
        @(posedge clk);
        model_update(sw, rst);
        #1;
    endtask

    task automatic step(input string name, input logic [N-1:0] sw, input logic rst);
        drive(sw, rst);
        check_vec(name, dut_out(), {e_press, e_rel, e_long, e_rep, e_held});
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] sw;
        logic [N-1:0] press, rel, held;
    } vec_t;

    vec_t vt [19];

    int press_at, long_at, rep_at, n_press, n_long, n_rep, rel_at;

    initial begin
        clk = 1'b0;
        i_Reset = 1'b1;
        i_Switches = '0;
        m_prev = '0;
        for (int k = 0; k < N; k++) begin
            m_held[k] = 1'b0;
            m_t0[k] = 0;
        end

        // rst, sw, press, release, held (long/repeat always 0 in this table)
        vt[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[1]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        vt[2]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        vt[3]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        vt[4]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        vt[5]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        vt[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vt[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[8]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
        vt[9]  = '{1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
        vt[10] = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        vt[11] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        vt[12] = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        vt[13] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[14] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0010};
        vt[15] = '{1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        vt[16] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
        vt[17] = '{1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        vt[18] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        #1;
        for (int i = 0; i < 19; i++) begin
            drive(vt[i].sw, vt[i].rst);
            check_vec($sformatf("vec%0d", i), dut_out(),
                      {vt[i].press, vt[i].rel, 4'b0000, 4'b0000, vt[i].held});
        end

        // Long hold on bit0: press, long at +L, repeats every R, release on drop.
        step("rst1", 4'b0000, 1'b1);
        for (int i = 0; i < 9; i++) step("idle1", 4'b0000, 1'b0);
        press_at = -1; long_at = -1; rep_at = -1; n_press = 0; n_long = 0; n_rep = 0;
        for (int i = 0; i < 20; i++) begin
            step("hold1", 4'b0001, 1'b0);
            if (o_Press[0])  begin n_press++; if (press_at < 0) press_at = i; end
            if (o_Long[0])   begin n_long++;  if (long_at < 0)  long_at = i;  end
            if (o_Repeat[0]) begin n_rep++;   if (rep_at < 0)   rep_at = i;   end
        end
        check_int("t1_press_at", press_at, 0);
        check_int("t1_press_cnt", n_press, 1);
        check_int("t1_long_at", long_at, L);
        check_int("t1_long_cnt", n_long, 1);
        check_int("t1_rep_cnt", n_rep, REP_EN ? 3 : 0);
        if (REP_EN) check_int("t1_rep_first", rep_at, L + R);
        step("rel1", 4'b0000, 1'b0);
        check_int("t1_release", int'(o_Release), 1);
        check_int("t1_held_off", int'(o_Held), 0);

        // Release lands on the cycle the hold counter expires: release wins, no long.
        step("idle3", 4'b0000, 1'b0);
        n_long = 0;
        for (int i = 0; i < L; i++) begin
            step("hold3", 4'b0001, 1'b0);
            if (o_Long[0]) n_long++;
        end
        step("rel3", 4'b0000, 1'b0);
        check_int("t3_release", int'(o_Release), 1);
        check_int("t3_long_at_rel", int'(o_Long), 0);
        for (int i = 0; i < 4; i++) begin
            step("after3", 4'b0000, 1'b0);
            if (o_Long[0]) n_long++;
        end
        check_int("t3_long_cnt", n_long, 0);

        // Two switches together, then only one released.
        step("p5", 4'b1001, 1'b0);
        check_int("t5_press", int'(o_Press), 9);
        for (int i = 1; i <= L; i++) step("h5", 4'b1001, 1'b0);
        check_int("t5_long", int'(o_Long), 9);
        step("h5", 4'b1001, 1'b0);
        step("h5", 4'b1001, 1'b0);
        step("r5", 4'b0001, 1'b0);
        check_int("t5_release", int'(o_Release), 8);
        n_rep = int'(o_Repeat[0]);
        for (int i = 0; i < 6; i++) begin
            step("h5b", 4'b0001, 1'b0);
            n_rep += int'(o_Repeat[0]);
        end
        check_int("t5_rep_cnt", n_rep, REP_EN ? 3 : 0);
        check_int("t5_held", int'(o_Held), 1);
        step("r5b", 4'b0000, 1'b0);

        // Random stimulus: sticky switches with occasional toggles and rare resets.
        begin
            logic [N-1:0] sw;
            sw = '0;
            for (int i = 0; i < 2000; i++) begin
                for (int k = 0; k < N; k++)
                    if ($urandom_range(0, 9) == 0) sw[k] = ~sw[k];
                step("rand", sw, ($urandom_range(0, 199) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_event_gen.md
Name: switch_event_gen

Overview:
Per-switch event generator between the debouncer and the state machine / counters in the 7-segment counter design. It takes the debounced switch levels and produces single-cycle press, release, long-press and auto-repeat pulses, plus a held level. The mode FSM and the switch counters consume these events, so none of them needs its own edge detection. All switches are handled independently by identical per-switch logic.

Parameters:
NUM_SWITCHES, 4, number of independent switch channels.
LONG_PRESS_CYCLES, 25000000, cycles from o_Press to o_Long (1 s at 25 MHz); legal range >= 2.
REPEAT_CYCLES, 5000000, cycles between o_Long and the first o_Repeat, and between successive o_Repeat pulses (200 ms); legal range >= 2.

Ports:
i_Clk  in  1  system clock; all logic on posedge.
i_Reset  in  1  synchronous reset, active-high.
i_Switches  in  NUM_SWITCHES  debounced switch levels, 1 = pressed; bit k = switch k+1.
o_Press  out  NUM_SWITCHES  1-cycle pulse per switch on an accepted press.
o_Release  out  NUM_SWITCHES  1-cycle pulse per switch on release of an accepted press.
o_Long  out  NUM_SWITCHES  1-cycle pulse when the hold reaches LONG_PRESS_CYCLES.
o_Repeat  out  NUM_SWITCHES  1-cycle auto-repeat pulse while long-held.
o_Held  out  NUM_SWITCHES  level: 1 while the switch FSM is not IDLE.

Behaviour:
- All outputs are registered. Reset value of every output bit is 0.
- Reset: every FSM goes to IDLE and every counter clears to 0. r_Prev[k] loads the current i_Switches[k].
- Consequence of the reset rule: a switch held through reset produces no events until it is released and pressed again.
- Per-switch state: r_Prev (last sample), 2-bit FSM, down-counter wide enough for max(LONG_PRESS_CYCLES, REPEAT_CYCLES).
- Rise = i_Switches[k] & ~r_Prev[k]. Fall = ~i_Switches[k] & r_Prev[k]. r_Prev is updated every cycle.
- IDLE:
  - On rise: o_Press pulses on the next cycle, FSM -> HELD, counter loads LONG_PRESS_CYCLES-1.
  - On fall: no event (this is the release of a switch held through reset).
- HELD:
  - While the input stays 1, the counter decrements each cycle.
  - At counter == 0: o_Long pulses, FSM -> LONG, counter loads REPEAT_CYCLES-1.
  - Net timing: o_Long asserts exactly LONG_PRESS_CYCLES cycles after o_Press.
- LONG:
  - The counter decrements each cycle.
  - At counter == 0: o_Repeat pulses and the counter reloads REPEAT_CYCLES-1. Period is exactly REPEAT_CYCLES.
- Fall in HELD or LONG: o_Release pulses on the next cycle, FSM -> IDLE, counter -> 0.
- Release and terminal count in the same cycle: release wins; no o_Long or o_Repeat is emitted.
- A 1-cycle glitch (rise then immediate fall) produces o_Press followed by o_Release on consecutive cycles. Debouncing is upstream.
- Channels are fully independent. Simultaneous events on several switches assert the corresponding bits in the same cycle.
- o_Held = 1 in HELD and LONG, 0 in IDLE. It rises in the same cycle as o_Press and falls in the same cycle as o_Release.
- At most one of o_Press / o_Release / o_Long / o_Repeat is high per bit per cycle.
- Reset asserted mid-hold: outputs clear on the next edge, with no o_Release.

Optional Feature:
Macro SWITCH_EVENT_REPEAT_EN.
- Defined: LONG state behaves as above, with periodic o_Repeat.
- Undefined: o_Repeat is tied to 0 and the repeat reload logic is removed. LONG simply waits for release; o_Long and o_Release are unchanged.

Test Plan:
(Bench parameters: NUM_SWITCHES=4, LONG_PRESS_CYCLES=8, REPEAT_CYCLES=3, SWITCH_EVENT_REPEAT_EN defined.)
1. Reset with i_Switches=0000, raise bit0 at cycle 10, hold -> o_Press[0] at 11; o_Held[0]=1 from 11; o_Long[0] at 19; o_Repeat[0] at 22, 25, 28.
2. Bit0 held 5 cycles then dropped -> o_Press[0] once, o_Release[0] 5 cycles later, no o_Long; o_Held back to 0 with o_Release.
3. Release timed on the same cycle the HELD counter reaches 0 -> o_Release[0] only; o_Long[0] never asserts.
4. Hold i_Switches=0010 through reset, release, press again -> no events on the first release; o_Press[1] one cycle after the re-press.
5. Raise bits 0 and 3 in the same cycle -> o_Press=1001 in one cycle; o_Long=1001 8 cycles later; releasing only bit3 gives o_Release=1000 while bit0 keeps repeating.
6. Rebuild without SWITCH_EVENT_REPEAT_EN, 20-cycle hold -> o_Long at +8, o_Repeat stays 0000, o_Release on drop.
